// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store bus controller with byte-lane steering, load extension and bus timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module lsu_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  LoadPartM,
  input  logic [1:0]  StoreSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemBE,
  output logic [31:0] DMemWData,
  input  logic        DMemGnt,
  input  logic        DMemRValid,
  input  logic [31:0] DMemRData,
  output logic        StallLSU,
  output logic [31:0] ReadDataM,
  output logic        MisalignFault,
  output logic        BusError
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  state_e state_q, state_d;
  logic st_q, st_d, uns_q, uns_d, req_q, req_d, we_q, we_d, mf_q, mf_d, berr_q, berr_d;
  logic [1:0] sz, sz_q, sz_d, off, off_q, off_d;
  logic [3:0] be, be_q, be_d;
  logic [15:0] lane;
  logic [31:0] wdata, addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ld_ext;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic acc, mis_trap, timeout;
  assign acc = MemReadM | MemWriteM;
  // Stores win when both requests are raised; undefined encodings fall through to word.
  always_comb begin
    sz = MemWriteM ? (StoreSrcM == 2'b10 ? SZ_B : StoreSrcM == 2'b01 ? SZ_H : SZ_W)
                   : (LoadPartM[1:0] == 2'b00 ? SZ_B : LoadPartM[1:0] == 2'b01 ? SZ_H : SZ_W);
    off = sz == SZ_B ? ALUResultM[1:0] : sz == SZ_H ? {ALUResultM[1], 1'b0} : 2'b00;
    be = sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? 4'b0011 << off : 4'b1111;
    wdata = sz == SZ_B ? {4{WriteDataM[7:0]}} : sz == SZ_H ? {2{WriteDataM[15:0]}} : WriteDataM;
  end
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_trap = (sz == SZ_H && ALUResultM[0]) || (sz == SZ_W && ALUResultM[1:0] != 2'b00);
`else
  assign mis_trap = 1'b0;
`endif
  assign lane = 16'(DMemRData >> {off_q, 3'b000});
  assign ld_ext = sz_q == SZ_B ? {{24{~uns_q & lane[7]}}, lane[7:0]}
                : sz_q == SZ_H ? {{16{~uns_q & lane[15]}}, lane[15:0]} : DMemRData;
  assign cnt_inc = cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1);
  assign timeout = cnt_q >= CNT_LAST;
  assign StallLSU = ~reset & ((state_q == IDLE & acc) | state_q == REQ | state_q == WAIT);
  always_comb begin
    state_d = state_q;
    st_d = st_q;
    uns_d = uns_q;
    sz_d = sz_q;
    off_d = off_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    mf_d = 1'b0;
    berr_d = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        st_d = MemWriteM;
        uns_d = LoadPartM[2];
        sz_d = sz;
        off_d = off;
        cnt_d = '0;
        if (mis_trap) begin
          state_d = DONE;
          mf_d = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = REQ;
          req_d = 1'b1;
          we_d = MemWriteM;
          addr_d = {ALUResultM[31:2], 2'b00};
          be_d = be;
          wdata_d = wdata;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (DMemGnt && st_q) begin
          state_d = DONE;
          req_d = 1'b0;
          we_d = 1'b0;
          rdata_d = '0;
        end else if (timeout) begin
          state_d = DONE;
          req_d = 1'b0;
          we_d = 1'b0;
          berr_d = 1'b1;
          rdata_d = '0;
        end else if (DMemGnt) begin
          state_d = WAIT;
          req_d = 1'b0;
          we_d = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (DMemRValid) begin
          state_d = DONE;
          rdata_d = ld_ext;
        end else if (timeout) begin
          state_d = DONE;
          berr_d = 1'b1;
          rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      st_q <= 1'b0;
      uns_q <= 1'b0;
      sz_q <= SZ_B;
      off_q <= 2'b00;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      mf_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q <= st_d;
      uns_q <= uns_d;
      sz_q <= sz_d;
      off_q <= off_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      mf_q <= mf_d;
      berr_q <= berr_d;
    end
  end
  assign DMemReq = req_q;
  assign DMemWe = we_q;
  assign DMemAddr = addr_q;
  assign DMemBE = be_q;
  assign DMemWData = wdata_q;
  assign ReadDataM = rdata_q;
  assign MisalignFault = mf_q;
  assign BusError = berr_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table plus hand sequences for stalls, timeout and reset abort.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0] LoadPartM = '0;
  logic [1:0] StoreSrcM = '0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic DMemReq, DMemWe, DMemGnt = 1'b0, DMemRValid = 1'b0;
  logic [31:0] DMemAddr, DMemWData, DMemRData = '0, ReadDataM;
  logic [3:0] DMemBE;
  logic StallLSU, MisalignFault, BusError;
  always #5 clk = ~clk;
  lsu_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .LoadPartM(LoadPartM), .StoreSrcM(StoreSrcM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemBE(DMemBE), .DMemWData(DMemWData), .DMemGnt(DMemGnt), .DMemRValid(DMemRValid),
    .DMemRData(DMemRData), .StallLSU(StallLSU), .ReadDataM(ReadDataM),
    .MisalignFault(MisalignFault), .BusError(BusError)
  );
  typedef struct {
    logic rd, wr;
    logic [2:0] lp;
    logic [1:0] ss;
    logic [31:0] addr, wdata, mem, e_addr;
    logic [3:0] e_be;
    logic [31:0] e_wdata, e_rdata;
  } vec_t;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam int NRUN = 11;
`else
  localparam int NRUN = 13;
`endif
  vec_t v [13];
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t t, input int i);
    int stalls = 0;
    @(negedge clk);
    MemReadM = t.rd; MemWriteM = t.wr; LoadPartM = t.lp; StoreSrcM = t.ss;
    ALUResultM = t.addr; WriteDataM = t.wdata;
    #1 stalls += int'(StallLSU);
    chk($sformatf("v%0d_idle_req", i), 32'(DMemReq), 32'(0));
    @(negedge clk); #1;
    stalls += int'(StallLSU);
    chk($sformatf("v%0d_req", i), 32'(DMemReq), 32'(1));
    chk($sformatf("v%0d_addr", i), DMemAddr, t.e_addr);
    chk($sformatf("v%0d_be", i), 32'(DMemBE), 32'(t.e_be));
    chk($sformatf("v%0d_we", i), 32'(DMemWe), 32'(t.wr));
    if (t.wr) chk($sformatf("v%0d_wdata", i), DMemWData, t.e_wdata);
    DMemGnt = 1'b1;
    @(negedge clk); #1;
    DMemGnt = 1'b0;
    if (!t.wr) begin
      stalls += int'(StallLSU);
      chk($sformatf("v%0d_req_drop", i), 32'(DMemReq), 32'(0));
      DMemRValid = 1'b1; DMemRData = t.mem;
      @(negedge clk); #1;
      DMemRValid = 1'b0;
      chk($sformatf("v%0d_rdata", i), ReadDataM, t.e_rdata);
    end
    chk($sformatf("v%0d_done_stall", i), 32'(StallLSU), 32'(0));
    chk($sformatf("v%0d_done_req", i), 32'(DMemReq), 32'(0));
    chk($sformatf("v%0d_flags", i), {30'b0, MisalignFault, BusError}, 32'(0));
    chk($sformatf("v%0d_stalls", i), 32'(stalls), 32'(t.wr ? 2 : 3));
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask
  initial begin
    int req_cycles, berr_pulses;
    bit fin;
    v[0]  = '{1'b1, 1'b0, 3'b000, 2'b00, 32'h103, 32'h0, 32'h80FF_FFFF, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80};
    v[1]  = '{1'b1, 1'b0, 3'b100, 2'b00, 32'h101, 32'h0, 32'h1234_80FF, 32'h100, 4'b0010, 32'h0, 32'h0000_0080};
    v[2]  = '{1'b1, 1'b0, 3'b001, 2'b00, 32'h202, 32'h0, 32'h8001_1234, 32'h200, 4'b1100, 32'h0, 32'hFFFF_8001};
    v[3]  = '{1'b1, 1'b0, 3'b101, 2'b00, 32'h200, 32'h0, 32'h8001_F234, 32'h200, 4'b0011, 32'h0, 32'h0000_F234};
    v[4]  = '{1'b1, 1'b0, 3'b010, 2'b00, 32'h300, 32'h0, 32'hDEAD_BEEF, 32'h300, 4'b1111, 32'h0, 32'hDEAD_BEEF};
    v[5]  = '{1'b1, 1'b0, 3'b011, 2'b00, 32'h304, 32'h0, 32'h8000_0001, 32'h304, 4'b1111, 32'h0, 32'h8000_0001};
    v[6]  = '{1'b0, 1'b1, 3'b000, 2'b10, 32'h105, 32'h1234_56A7, 32'h0, 32'h104, 4'b0010, 32'hA7A7_A7A7, 32'h0};
    v[7]  = '{1'b0, 1'b1, 3'b000, 2'b01, 32'h202, 32'h1234_ABCD, 32'h0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0};
    v[8]  = '{1'b0, 1'b1, 3'b000, 2'b00, 32'h40, 32'hCAFE_F00D, 32'h0, 32'h40, 4'b1111, 32'hCAFE_F00D, 32'h0};
    v[9]  = '{1'b0, 1'b1, 3'b000, 2'b11, 32'h48, 32'h0102_0304, 32'h0, 32'h48, 4'b1111, 32'h0102_0304, 32'h0};
    v[10] = '{1'b1, 1'b1, 3'b010, 2'b10, 32'h10, 32'h0000_0055, 32'h0, 32'h10, 4'b0001, 32'h5555_5555, 32'h0};
    v[11] = '{1'b0, 1'b1, 3'b000, 2'b00, 32'h6, 32'h1122_3344, 32'h0, 32'h4, 4'b1111, 32'h1122_3344, 32'h0};
    v[12] = '{1'b1, 1'b0, 3'b001, 2'b00, 32'h203, 32'h0, 32'h7FFF_0000, 32'h200, 4'b1100, 32'h0, 32'h0000_7FFF};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {26'b0, StallLSU, DMemReq, DMemWe, MisalignFault, BusError, 1'b0}, 32'(0));
    chk("rst_addr", DMemAddr, 32'(0));
    chk("rst_be", 32'(DMemBE), 32'(0));
    chk("rst_wdata", DMemWData, 32'(0));
    chk("rst_rdata", ReadDataM, 32'(0));
    reset = 1'b0;
    for (int i = 0; i < NRUN; i++) run_vec(v[i], i);
    // LHU with grant withheld for five REQ cycles
    @(negedge clk);
    MemReadM = 1'b1; LoadPartM = 3'b101; ALUResultM = 32'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("hold%0d_req", i), 32'(DMemReq), 32'(1));
      chk($sformatf("hold%0d_addr", i), DMemAddr, 32'h4);
      chk($sformatf("hold%0d_be", i), 32'(DMemBE), 32'(4'b0011));
      chk($sformatf("hold%0d_stall", i), 32'(StallLSU), 32'(1));
    end
    @(negedge clk); #1;
    chk("hold5_req", 32'(DMemReq), 32'(1));
    DMemGnt = 1'b1;
    @(negedge clk); #1;
    DMemGnt = 1'b0; DMemRValid = 1'b1; DMemRData = 32'h1111_8765;
    @(negedge clk); #1;
    DMemRValid = 1'b0;
    chk("hold_rdata", ReadDataM, 32'h0000_8765);
    chk("hold_stall", 32'(StallLSU), 32'(0));
    MemReadM = 1'b0;
    // reset while waiting for read data, then a late RValid
    @(negedge clk);
    MemReadM = 1'b1; LoadPartM = 3'b010; ALUResultM = 32'h8;
    @(negedge clk); #1;
    DMemGnt = 1'b1;
    @(negedge clk); #1;
    DMemGnt = 1'b0;
    chk("rstw_wait_stall", 32'(StallLSU), 32'(1));
    reset = 1'b1; MemReadM = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0; DMemRValid = 1'b1; DMemRData = 32'hFFFF_FFFF;
    chk("rstw_stall", 32'(StallLSU), 32'(0));
    chk("rstw_req", 32'(DMemReq), 32'(0));
    chk("rstw_rdata0", ReadDataM, 32'(0));
    @(negedge clk); #1;
    DMemRValid = 1'b0;
    chk("rstw_late_rdata", ReadDataM, 32'(0));
    chk("rstw_late_stall", 32'(StallLSU), 32'(0));
    chk("rstw_late_req", 32'(DMemReq), 32'(0));
    // LW with grant never given: bus timeout
    @(negedge clk);
    MemReadM = 1'b1; LoadPartM = 3'b010; ALUResultM = 32'h20;
    req_cycles = 0; berr_pulses = 0; fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk); #1;
      if (BusError) berr_pulses++;
      if (DMemReq) req_cycles++;
      else fin = 1'b1;
    end
    chk("to_req_cycles", 32'(req_cycles), 32'(64));
    chk("to_berr", 32'(BusError), 32'(1));
    chk("to_rdata", ReadDataM, 32'(0));
    chk("to_stall", 32'(StallLSU), 32'(0));
    MemReadM = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (BusError) berr_pulses++;
    end
    chk("to_pulses", 32'(berr_pulses), 32'(1));
    chk("to_req_after", 32'(DMemReq), 32'(0));
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    MemWriteM = 1'b1; StoreSrcM = 2'b00; ALUResultM = 32'h6; WriteDataM = 32'h1122_3344;
    #1 chk("mis_stall_idle", 32'(StallLSU), 32'(1));
    @(negedge clk); #1;
    chk("mis_fault", 32'(MisalignFault), 32'(1));
    chk("mis_req", 32'(DMemReq), 32'(0));
    chk("mis_rdata", ReadDataM, 32'(0));
    chk("mis_stall", 32'(StallLSU), 32'(0));
    MemWriteM = 1'b0;
    @(negedge clk); #1;
    chk("mis_pulse", 32'(MisalignFault), 32'(0));
    chk("mis_req_after", 32'(DMemReq), 32'(0));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum cycles spent in REQ+WAIT before the access is aborted as a bus error.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 MemReadM  in  1  memory-stage load request.
REQ-005 MemWriteM  in  1  memory-stage store request.
REQ-006 LoadPartM  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 StoreSrcM  in  2  store type: 10 SB, 01 SH, 00 SW.
REQ-008 ALUResultM  in  32  byte address.
REQ-009 WriteDataM  in  32  store data from rs2.
REQ-010 DMemReq  out  1  request to data memory.
REQ-011 DMemWe  out  1  write strobe, qualified by DMemReq.
REQ-012 DMemAddr  out  32  word-aligned address (bits [1:0] = 00).
REQ-013 DMemBE  out  4  byte enables.
REQ-014 DMemWData  out  32  lane-replicated store data.
REQ-015 DMemGnt  in  1  memory accepted request this cycle.
REQ-016 DMemRValid  in  1  read data valid.
REQ-017 DMemRData  in  32  read data word.
REQ-018 StallLSU  out  1  freezes F/D/E/M registers.
REQ-019 ReadDataM  out  32  extended load result, valid in DONE.
REQ-020 MisalignFault  out  1  one-cycle fault pulse.
REQ-021 BusError  out  1  one-cycle timeout pulse.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-023 IDLE with MemReadM or MemWriteM = 1 SHALL latch all M-stage inputs, assert StallLSU combinationally that cycle, and move to REQ.
REQ-024 MemReadM and MemWriteM both 1 SHALL be treated as a store only.
REQ-025 DMemReq, DMemWe, DMemAddr, DMemBE, DMemWData SHALL be registered and held stable throughout REQ until DMemGnt = 1 is sampled.
REQ-026 On grant: store SHALL go to DONE; load SHALL go to WAIT, with DMemReq deasserted the next cycle.
REQ-027 WAIT SHALL capture DMemRData when DMemRValid = 1 and go to DONE; DMemRValid in any other state SHALL be ignored.
REQ-028 DONE SHALL last exactly one cycle, deassert StallLSU, drive ReadDataM, and return to IDLE; minimum load latency is 3 stall cycles.
REQ-029 Byte enables: SB 0001 << addr[1:0]; SH 0011 << (2*addr[1]); SW 1111.
REQ-030 Store data: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-031 Loads SHALL select the addressed byte/halfword lane; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-032 A saturating counter of ceil(log2(TIMEOUT+1)) bits, cleared on IDLE->REQ, SHALL count REQ+WAIT cycles; reaching TIMEOUT SHALL drop DMemReq, go to DONE, pulse BusError, and force ReadDataM = 0.
REQ-033 An undefined LoadPartM/StoreSrcM encoding SHALL complete as LW/SW respectively.

Reset
REQ-034 Reset SHALL force IDLE; StallLSU, DMemReq, DMemWe, MisalignFault, BusError = 0; DMemAddr, DMemBE, DMemWData, ReadDataM, counter = 0.
REQ-035 Reset asserted mid-access SHALL abandon the access with no further DMemReq; a late DMemRValid SHALL be ignored.

Configuration
REQ-036 Macro LSU_MISALIGN_TRAP_EN defined: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=00, SHALL skip REQ, go IDLE->DONE, pulse MisalignFault, set ReadDataM = 0, and issue no memory access.
REQ-037 Macro undefined: offending low address bits SHALL be treated as 0 (access aligned down) and MisalignFault SHALL be tied 0.

Verification
REQ-038 LB at 0x103, DMemGnt immediate, RValid next cycle with 0x80FF_FFFF -> DMemAddr 0x100, ReadDataM 0xFFFF_FF80, StallLSU high 3 cycles.
REQ-039 SH at 0x202, WriteDataM 0x1234_ABCD -> DMemBE 1100, DMemWData 0xABCD_ABCD, DMemWe 1, DONE one cycle after grant.
REQ-040 LHU at 0x4, DMemGnt held low 5 cycles -> request fields stable all 5 cycles, ReadDataM zero-extended after RValid.
REQ-041 LW with DMemGnt never asserted, TIMEOUT=64 -> BusError pulse exactly once after 64 cycles, ReadDataM 0, DMemReq low.
REQ-042 SW at 0x6 -> with LSU_MISALIGN_TRAP_EN: MisalignFault pulse, no DMemReq; without: DMemAddr 0x4, DMemBE 1111.
REQ-043 Reset asserted in WAIT, then DMemRValid -> FSM IDLE, StallLSU 0, ReadDataM 0, no state change.
